multi_target_tracker: RTL and testbench

- Parametrised successor to the single-colour orange classifier in the robot vision path.
- Tracks NUM_TARGETS colour classes per frame from per-pixel match bits (upstream colour thresholds), accumulating pixel count and x-coordinate sum per target.
- At each frame boundary, classifies each target's horizontal position into left/centre/right and applies frame-level hysteresis (multi-frame persistence, which the single-target classifier lacks).
- Sits in the clk_25_vga domain between the RGB/colour-match stage and the drive FSM; also reports the highest-priority detected target.

---
 rtl/multi_target_tracker.sv | 226 ++++++++++++++++++++++
 tb/tb_multi_target_tracker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_target_tracker.sv
// multi_target_tracker: per-frame colour-target accumulation with frame-level
// hysteresis, left/centre/right zoning and priority selection of the best target.
module multi_target_tracker #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int NUM_TARGETS = 2,
  parameter int MIN_PIXELS  = 64,
  parameter int PERSIST     = 2,
  localparam int IW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic                     pixel_valid,
  input  logic [NUM_TARGETS-1:0]   match,
  output logic [NUM_TARGETS-1:0]   detected,
  output logic [3*NUM_TARGETS-1:0] direction,
  output logic                     results_valid,
  output logic                     best_valid,
  output logic [IW-1:0]            best_index,
  output logic [2:0]               best_direction,
  output logic                     overrun
);

  localparam int CW = $clog2(H_ACTIVE*V_ACTIVE+1);
  localparam int SW = $clog2(H_ACTIVE*H_ACTIVE*V_ACTIVE+1);
  localparam int ZW = SW + 2;
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = $clog2(V_ACTIVE+1);
  localparam int PW = $clog2(PERSIST+1);

  typedef enum logic {ST_ACCUM, ST_EVAL} state_t;

  state_t                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [XW-1:0]            x_q, x_d;
  logic [YW-1:0]            y_q, y_d;
  logic [CW-1:0]            cnt_q [NUM_TARGETS];
  logic [CW-1:0]            cnt_d [NUM_TARGETS];
  logic [SW-1:0]            xsum_q [NUM_TARGETS];
  logic [SW-1:0]            xsum_d [NUM_TARGETS];
  logic [CW-1:0]            snap_cnt_q [NUM_TARGETS];
  logic [CW-1:0]            snap_cnt_d [NUM_TARGETS];
  logic [SW-1:0]            snap_xsum_q [NUM_TARGETS];
  logic [SW-1:0]            snap_xsum_d [NUM_TARGETS];
  logic [PW-1:0]            hit_streak_q [NUM_TARGETS];
  logic [PW-1:0]            hit_streak_d [NUM_TARGETS];
  logic [PW-1:0]            miss_streak_q [NUM_TARGETS];
  logic [PW-1:0]            miss_streak_d [NUM_TARGETS];
  logic [NUM_TARGETS-1:0]   detected_q, detected_d;
  logic [3*NUM_TARGETS-1:0] direction_q, direction_d;
  logic                     results_valid_q, results_valid_d;
  logic                     best_valid_q, best_valid_d;
  logic [IW-1:0]            best_index_q, best_index_d;
  logic [2:0]               best_direction_q, best_direction_d;
  logic                     overrun_q, overrun_d;

  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic          take;

  logic [CW-1:0] sel_cnt;
  logic [SW-1:0] sel_xsum;
  logic [ZW-1:0] x3, ch, ch2;
  logic          hit;
  logic [2:0]    zone;
  logic [PW-1:0] hs_next, ms_next;

  // Pixel coordinates, live accumulators and frame-boundary snapshots.
  // A pixel coincident with frame_start is pixel (0,0) of the new frame, so
  // the coordinate/accumulator base is taken as zero on that cycle.
  always_comb begin
    cur_x = frame_start ? '0 : x_q;
    cur_y = frame_start ? '0 : y_q;
    take  = pixel_valid && (cur_y < YW'(V_ACTIVE));
    x_d   = cur_x;
    y_d   = cur_y;
    if (take) begin
      if (cur_x == XW'(H_ACTIVE-1)) begin
        x_d = '0;
        y_d = cur_y + YW'(1);
      end else begin
        x_d = cur_x + XW'(1);
      end
    end
    for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
      cnt_d[i]       = frame_start ? '0 : cnt_q[i];
      xsum_d[i]      = frame_start ? '0 : xsum_q[i];
      snap_cnt_d[i]  = frame_start ? cnt_q[i]  : snap_cnt_q[i];
      snap_xsum_d[i] = frame_start ? xsum_q[i] : snap_xsum_q[i];
      if (take && match[i]) begin
        cnt_d[i]  = cnt_d[i] + CW'(1);
        xsum_d[i] = xsum_d[i] + SW'(cur_x);
      end
    end
  end

  // Evaluation FSM: one target per cycle, hysteresis, zoning and best-target pick.
  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    hit_streak_d     = hit_streak_q;
    miss_streak_d    = miss_streak_q;
    detected_d       = detected_q;
    direction_d      = direction_q;
    results_valid_d  = 1'b0;
    best_valid_d     = best_valid_q;
    best_index_d     = best_index_q;
    best_direction_d = best_direction_q;
    overrun_d        = overrun_q;
    hs_next          = '0;
    ms_next          = '0;

    sel_cnt  = snap_cnt_q[idx_q];
    sel_xsum = snap_xsum_q[idx_q];
    x3       = ZW'(sel_xsum) + (ZW'(sel_xsum) << 1);
    ch       = ZW'(sel_cnt) * ZW'(H_ACTIVE);
    ch2      = ch << 1;
    hit      = ZW'(sel_cnt) >= ZW'(MIN_PIXELS);
    if (x3 < ch) begin
      zone = 3'b001;
    end else if (x3 >= ch2) begin
      zone = 3'b100;
    end else begin
      zone = 3'b010;
    end

    if (frame_start) begin
      // A new frame aborts any evaluation in flight; targets already updated
      // keep their new state and the aborted pass never raises results_valid.
      if (state_q == ST_EVAL) begin
        overrun_d = 1'b1;
      end
      state_d = ST_EVAL;
      idx_d   = '0;
    end else if (state_q == ST_EVAL) begin
      if (hit) begin
        hs_next = (hit_streak_q[idx_q] == PW'(PERSIST)) ? PW'(PERSIST)
                                                        : hit_streak_q[idx_q] + PW'(1);
        if (hs_next == PW'(PERSIST)) begin
          detected_d[idx_q] = 1'b1;
        end
      end else begin
        ms_next = (miss_streak_q[idx_q] == PW'(PERSIST)) ? PW'(PERSIST)
                                                         : miss_streak_q[idx_q] + PW'(1);
        if (ms_next == PW'(PERSIST)) begin
          detected_d[idx_q] = 1'b0;
        end
      end
      hit_streak_d[idx_q]  = hs_next;
      miss_streak_d[idx_q] = ms_next;
      direction_d[3*idx_q +: 3] = detected_d[idx_q]
                                  ? (hit ? zone : direction_q[3*idx_q +: 3])
                                  : 3'b000;

      if (idx_q == IW'(NUM_TARGETS-1)) begin
        state_d          = ST_ACCUM;
        results_valid_d  = 1'b1;
        best_valid_d     = |detected_d;
        best_index_d     = '0;
        best_direction_d = '0;
        // Scan from the highest index down so the lowest detected index wins.
        for (int unsigned k = 0; k < NUM_TARGETS; k++) begin
          if (detected_d[NUM_TARGETS-1-k]) begin
            best_index_d     = IW'(NUM_TARGETS-1-k);
            best_direction_d = direction_d[3*(NUM_TARGETS-1-k) +: 3];
          end
        end
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_ACCUM;
      idx_q            <= '0;
      x_q              <= '0;
      y_q              <= '0;
      detected_q       <= '0;
      direction_q      <= '0;
      results_valid_q  <= 1'b0;
      best_valid_q     <= 1'b0;
      best_index_q     <= '0;
      best_direction_q <= '0;
      overrun_q        <= 1'b0;
      for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
        cnt_q[i]         <= '0;
        xsum_q[i]        <= '0;
        snap_cnt_q[i]    <= '0;
        snap_xsum_q[i]   <= '0;
        hit_streak_q[i]  <= '0;
        miss_streak_q[i] <= '0;
      end
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      x_q              <= x_d;
      y_q              <= y_d;
      detected_q       <= detected_d;
      direction_q      <= direction_d;
      results_valid_q  <= results_valid_d;
      best_valid_q     <= best_valid_d;
      best_index_q     <= best_index_d;
      best_direction_q <= best_direction_d;
      overrun_q        <= overrun_d;
      cnt_q            <= cnt_d;
      xsum_q           <= xsum_d;
      snap_cnt_q       <= snap_cnt_d;
      snap_xsum_q      <= snap_xsum_d;
      hit_streak_q     <= hit_streak_d;
      miss_streak_q    <= miss_streak_d;
    end
  end

  assign detected       = detected_q;
  assign direction      = direction_q;
  assign results_valid  = results_valid_q;
  assign best_valid     = best_valid_q;
  assign best_index     = best_index_q;
  assign best_direction = best_direction_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_multi_target_tracker.sv
// Bench for multi_target_tracker: directed frame vectors with hand-computed
// results, plus overrun and mid-evaluation reset sequences.
module tb_multi_target_tracker;

  localparam int EXP_LAT = 2;

  logic       clk;
  logic       reset;
  logic       frame_start;
  logic       pixel_valid;
  logic [1:0] match;
  logic [1:0] detected;
  logic [5:0] direction;
  logic       results_valid;
  logic       best_valid;
  logic [0:0] best_index;
  logic [2:0] best_direction;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  multi_target_tracker #(
    .H_ACTIVE(16),
    .V_ACTIVE(4),
    .NUM_TARGETS(2),
    .MIN_PIXELS(4),
    .PERSIST(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_start(frame_start),
    .pixel_valid(pixel_valid),
    .match(match),
    .detected(detected),
    .direction(direction),
    .results_valid(results_valid),
    .best_valid(best_valid),
    .best_index(best_index),
    .best_direction(best_direction),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         lo0, hi0, ym0;
    int         lo1, hi1, ym1;
    int         extra;
    logic [1:0] det;
    logic [5:0] dir;
    logic       bv;
    logic       bi;
    logic [2:0] bd;
  } vec_t;

  vec_t tv [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Stream one 16x4 frame; target i matches x in [lo,hi] on lines y < ym.
  // Extra pixels after the last line carry match on all targets.
  task automatic send_pixels(input int lo0, input int hi0, input int ym0,
                             input int lo1, input int hi1, input int ym1,
                             input int extra);
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 16; x++) begin
        @(negedge clk);
        pixel_valid = 1'b1;
        match[0] = (x >= lo0) && (x <= hi0) && (y < ym0);
        match[1] = (x >= lo1) && (x <= hi1) && (y < ym1);
      end
    end
    for (int e = 0; e < extra; e++) begin
      @(negedge clk);
      pixel_valid = 1'b1;
      match = 2'b11;
    end
    @(negedge clk);
    pixel_valid = 1'b0;
    match = 2'b00;
  endtask

  // Pulse frame_start and wait (bounded) for results_valid.
  task automatic fs_and_wait(output int lat);
    logic got;
    @(negedge clk);
    frame_start = 1'b1;
    pixel_valid = 1'b0;
    match = 2'b00;
    @(negedge clk);
    frame_start = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (results_valid) begin
        got = 1'b1;
        lat = c;
      end
    end
  endtask

  task automatic check_outputs(input string tag, input logic [1:0] det, input logic [5:0] dir,
                               input logic bv, input logic bi, input logic [2:0] bd,
                               input logic ovr);
    chk({tag, " detected"}, 32'(detected), 32'(det));
    chk({tag, " direction"}, 32'(direction), 32'(dir));
    chk({tag, " best_valid"}, 32'(best_valid), 32'(bv));
    chk({tag, " best_index"}, 32'(best_index), 32'(bi));
    chk({tag, " best_direction"}, 32'(best_direction), 32'(bd));
    chk({tag, " overrun"}, 32'(overrun), 32'(ovr));
  endtask

  initial begin
    int lat;
    int rv_cnt;
    logic [1:0] c_det;
    logic [5:0] c_dir;
    logic       c_bv, c_bi, c_ovr;
    logic [2:0] c_bd;

    //           lo0 hi0 ym0 lo1 hi1 ym1 ext det    dir{t1,t0}        bv    bi    bd
    tv[0]  = '{1,  2,  4,  0,  0,  0,  0,  2'b00, {3'b000,3'b000}, 1'b0, 1'b0, 3'b000};
    tv[1]  = '{1,  2,  4,  0,  0,  0,  0,  2'b01, {3'b000,3'b001}, 1'b1, 1'b0, 3'b001};
    tv[2]  = '{0,  0,  0,  7,  8,  4,  0,  2'b01, {3'b000,3'b001}, 1'b1, 1'b0, 3'b001};
    tv[3]  = '{0,  0,  0,  7,  8,  4,  0,  2'b10, {3'b010,3'b000}, 1'b1, 1'b1, 3'b010};
    tv[4]  = '{13, 14, 4,  7,  8,  4,  0,  2'b10, {3'b010,3'b000}, 1'b1, 1'b1, 3'b010};
    tv[5]  = '{13, 14, 4,  7,  8,  4,  0,  2'b11, {3'b010,3'b100}, 1'b1, 1'b0, 3'b100};
    tv[6]  = '{0,  0,  0,  7,  8,  4,  0,  2'b11, {3'b010,3'b100}, 1'b1, 1'b0, 3'b100};
    tv[7]  = '{0,  0,  0,  0,  0,  0,  0,  2'b10, {3'b010,3'b000}, 1'b1, 1'b1, 3'b010};
    tv[8]  = '{0,  0,  0,  0,  0,  0,  0,  2'b00, {3'b000,3'b000}, 1'b0, 1'b0, 3'b000};
    tv[9]  = '{5,  5,  3,  5,  5,  4,  20, 2'b00, {3'b000,3'b000}, 1'b0, 1'b0, 3'b000};
    tv[10] = '{5,  5,  3,  5,  5,  4,  20, 2'b10, {3'b001,3'b000}, 1'b1, 1'b1, 3'b001};
    tv[11] = '{5,  5,  3,  5,  5,  4,  20, 2'b10, {3'b001,3'b000}, 1'b1, 1'b1, 3'b001};
    tv[12] = '{10, 10, 4,  11, 11, 4,  0,  2'b10, {3'b100,3'b000}, 1'b1, 1'b1, 3'b100};
    tv[13] = '{10, 10, 4,  11, 11, 4,  0,  2'b11, {3'b100,3'b010}, 1'b1, 1'b0, 3'b010};

    reset = 1'b1;
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    match = 2'b00;
    repeat (3) @(negedge clk);
    check_outputs("reset", 2'b00, 6'o00, 1'b0, 1'b0, 3'b000, 1'b0);
    chk("reset results_valid", 32'(results_valid), 32'd0);
    reset = 1'b0;

    // First frame after reset evaluates an empty frame.
    fs_and_wait(lat);
    chk("empty latency", 32'(lat), 32'(EXP_LAT));
    check_outputs("empty", 2'b00, 6'o00, 1'b0, 1'b0, 3'b000, 1'b0);
    @(negedge clk);
    chk("empty rv one cycle", 32'(results_valid), 32'd0);

    for (int v = 0; v < 14; v++) begin
      send_pixels(tv[v].lo0, tv[v].hi0, tv[v].ym0, tv[v].lo1, tv[v].hi1, tv[v].ym1, tv[v].extra);
      fs_and_wait(lat);
      chk($sformatf("v%0d latency", v), 32'(lat), 32'(EXP_LAT));
      check_outputs($sformatf("v%0d", v), tv[v].det, tv[v].dir, tv[v].bv, tv[v].bi, tv[v].bd, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d rv one cycle", v), 32'(results_valid), 32'd0);
    end

    // Back-to-back frame_start: second pulse lands in EVAL and restarts it.
    send_pixels(10, 10, 4, 0, 0, 0, 0);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    rv_cnt = 0;
    lat = 0;
    c_det = '0; c_dir = '0; c_bv = 1'b0; c_bi = 1'b0; c_bd = '0; c_ovr = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (results_valid) begin
        rv_cnt++;
        if (lat == 0) begin
          lat = c;
          c_det = detected; c_dir = direction; c_bv = best_valid;
          c_bi = best_index; c_bd = best_direction; c_ovr = overrun;
        end
      end
    end
    chk("overrun rv count", 32'(rv_cnt), 32'd1);
    chk("overrun latency", 32'(lat), 32'(EXP_LAT));
    chk("overrun flag", 32'(c_ovr), 32'd1);
    chk("overrun detected", 32'(c_det), 32'(2'b11));
    chk("overrun direction", 32'(c_dir), 32'({3'b100, 3'b010}));
    chk("overrun best_valid", 32'(c_bv), 32'd1);
    chk("overrun best_index", 32'(c_bi), 32'd0);
    chk("overrun best_direction", 32'(c_bd), 32'(3'b010));
    chk("overrun sticky", 32'(overrun), 32'd1);

    // Reset in the middle of EVAL: no results_valid, everything cleared.
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rv_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (results_valid) rv_cnt++;
    end
    chk("midreset rv count", 32'(rv_cnt), 32'd0);
    check_outputs("midreset", 2'b00, 6'o00, 1'b0, 1'b0, 3'b000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
